// File: rtl/kf8237_transfer_scheduler.sv
// 8237 transfer scheduler: arbitrates DREQ[3:0], runs the HRQ/HLDA handshake and S1-S4 cycle,
// and strobes the address/count register file. Terminates on underflow (TC).
module kf8237_transfer_scheduler (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] dma_request,
  input  logic [3:0] request_mask,
  input  logic       controller_disable,
  input  logic       rotating_priority,
  input  logic [7:0] transfer_mode,
  input  logic [3:0] autoinitialize_config,
  input  logic [3:0] address_hold_config_ch,
  input  logic [3:0] decrement_address_config_ch,
  input  logic       hold_acknowledge,
  input  logic       underflow,
  input  logic       clear_status,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge,
  output logic [3:0] transfer_register_select,
  output logic       next_word,
  output logic       initialize_current_register,
  output logic       address_hold_config,
  output logic       decrement_address_config,
  output logic       end_of_process,
  output logic [3:0] set_request_mask,
  output logic [3:0] terminal_count_status
);

  typedef enum logic [2:0] {
    ST_SI, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_TC
  } state_t;

  localparam logic [1:0] MODE_DEMAND = 2'b00;
  localparam logic [1:0] MODE_BLOCK  = 2'b10;

  state_t     state;
  logic [3:0] winner;
  logic [1:0] priority_ptr;
  logic       next_word_q;

  logic [3:0] eligible;
  logic [3:0] candidate;
  logic [1:0] winner_idx;
  logic [1:0] winner_mode;
  logic       in_service;
  logic       bus_abort;
  logic       tc_hit;
  logic       keep_going;
  logic       service_done;
  logic       go_idle;

  function automatic logic [3:0] pick_winner(input logic [3:0] elig, input logic rot,
                                             input logic [1:0] ptr);
    logic [3:0] w;
    logic [1:0] idx;
    w = '0;
    // Descending scan so the closest eligible channel to the start point is written last.
    for (int k = 3; k >= 0; k--) begin
      idx = rot ? ptr + k[1:0] : k[1:0];
      if (elig[idx]) begin
        w = '0;
        w[idx] = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  assign eligible    = dma_request & ~request_mask;
  assign candidate   = pick_winner(eligible, rotating_priority, priority_ptr);
  assign winner_idx  = onehot_index(winner);
  assign winner_mode = transfer_mode[{winner_idx, 1'b0} +: 2];

  assign in_service   = (state == ST_S1) || (state == ST_S2) || (state == ST_S3) || (state == ST_S4);
  assign bus_abort    = in_service && !hold_acknowledge;
  assign tc_hit       = (state == ST_S4) && hold_acknowledge && underflow;
  assign keep_going   = (state == ST_S4) && hold_acknowledge && !underflow &&
                        ((winner_mode == MODE_BLOCK) ||
                         ((winner_mode == MODE_DEMAND) && |(dma_request & winner)));
  assign service_done = ((state == ST_S4) && hold_acknowledge && !underflow && !keep_going) ||
                        (state == ST_TC);
  assign go_idle      = bus_abort || service_done;

  // A strobe already raised for S4 is withdrawn if the bus is lost in that same cycle.
  assign next_word                = next_word_q & hold_acknowledge;
  assign address_hold_config      = |(address_hold_config_ch & transfer_register_select);
  assign decrement_address_config = |(decrement_address_config_ch & transfer_register_select);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                       <= ST_SI;
      winner                      <= '0;
      priority_ptr                <= 2'd0;
      hold_request                <= 1'b0;
      dma_acknowledge             <= '0;
      transfer_register_select    <= '0;
      next_word_q                 <= 1'b0;
      initialize_current_register <= 1'b0;
      end_of_process              <= 1'b0;
      set_request_mask            <= '0;
      terminal_count_status       <= '0;
    end else begin
      next_word_q                 <= 1'b0;
      initialize_current_register <= 1'b0;
      end_of_process              <= 1'b0;
      set_request_mask            <= '0;

      case (state)
        ST_SI: begin
          if (!controller_disable && (eligible != 4'b0000)) begin
            winner       <= candidate;
            hold_request <= 1'b1;
            state        <= ST_S0;
          end
        end
        ST_S0: begin
          if (hold_acknowledge) begin
            state                    <= ST_S1;
            dma_acknowledge          <= winner;
            transfer_register_select <= winner;
          end
        end
        ST_S1: state <= ST_S2;
        ST_S2: state <= ST_S3;
        ST_S3: begin
          state       <= ST_S4;
          next_word_q <= 1'b1;
        end
        ST_S4: begin
          if (tc_hit) begin
            // Select stays valid one more cycle so the reload targets the right channel.
            state           <= ST_TC;
            end_of_process  <= 1'b1;
            dma_acknowledge <= '0;
            if (|(autoinitialize_config & winner)) initialize_current_register <= 1'b1;
            else                                   set_request_mask            <= winner;
          end else if (keep_going) begin
            state <= ST_S1;
          end
        end
        ST_TC: state <= ST_SI;
        default: state <= ST_SI;
      endcase

      if (go_idle) begin
        state                    <= ST_SI;
        hold_request             <= 1'b0;
        dma_acknowledge          <= '0;
        transfer_register_select <= '0;
        next_word_q              <= 1'b0;
      end

      if (service_done) priority_ptr <= winner_idx + 2'd1;

      terminal_count_status <= (clear_status ? 4'b0000 : terminal_count_status) |
                               (tc_hit ? winner : 4'b0000);
    end
  end

endmodule

// File: tb/tb_kf8237_transfer_scheduler.sv
// Bench for kf8237_transfer_scheduler: directed stimulus with a behavioural count register file;
// expected strobes are queued up front and a negedge monitor pops and compares them.
module tb_kf8237_transfer_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] dma_request;
  logic [3:0] request_mask;
  logic       controller_disable;
  logic       rotating_priority;
  logic [7:0] transfer_mode;
  logic [3:0] autoinitialize_config;
  logic [3:0] address_hold_config_ch;
  logic [3:0] decrement_address_config_ch;
  logic       hold_acknowledge;
  logic       underflow;
  logic       clear_status;
  logic       hold_request;
  logic [3:0] dma_acknowledge;
  logic [3:0] transfer_register_select;
  logic       next_word;
  logic       initialize_current_register;
  logic       address_hold_config;
  logic       decrement_address_config;
  logic       end_of_process;
  logic [3:0] set_request_mask;
  logic [3:0] terminal_count_status;

  always #5 clock = ~clock;

  kf8237_transfer_scheduler dut (
    .clock                       (clock),
    .reset_n                     (reset_n),
    .dma_request                 (dma_request),
    .request_mask                (request_mask),
    .controller_disable          (controller_disable),
    .rotating_priority           (rotating_priority),
    .transfer_mode               (transfer_mode),
    .autoinitialize_config       (autoinitialize_config),
    .address_hold_config_ch      (address_hold_config_ch),
    .decrement_address_config_ch (decrement_address_config_ch),
    .hold_acknowledge            (hold_acknowledge),
    .underflow                   (underflow),
    .clear_status                (clear_status),
    .hold_request                (hold_request),
    .dma_acknowledge             (dma_acknowledge),
    .transfer_register_select    (transfer_register_select),
    .next_word                   (next_word),
    .initialize_current_register (initialize_current_register),
    .address_hold_config         (address_hold_config),
    .decrement_address_config    (decrement_address_config),
    .end_of_process              (end_of_process),
    .set_request_mask            (set_request_mask),
    .terminal_count_status       (terminal_count_status)
  );

  typedef struct packed {
    logic [7:0] kind;
    logic [3:0] dat;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] pa_q[$];
  logic [31:0] pe_q[$];
  string       pn_q[$];
  int          checks = 0;
  int          errors = 0;

  // Behavioural current word count registers of the neighbouring register file.
  logic [15:0] base_cnt[4];
  logic [15:0] cur_cnt[4];
  logic        prog_stb;
  logic [1:0]  prog_ch;
  logic [1:0]  sel_idx;

  always_comb begin
    sel_idx = 2'd0;
    for (int i = 0; i < 4; i++) if (transfer_register_select[i]) sel_idx = i[1:0];
  end

  assign underflow = next_word && (cur_cnt[sel_idx] == 16'h0000);

  always @(posedge clock) begin
    if (prog_stb)                         cur_cnt[prog_ch] <= base_cnt[prog_ch];
    else if (next_word)                   cur_cnt[sel_idx] <= cur_cnt[sel_idx] - 16'h0001;
    else if (initialize_current_register) cur_cnt[sel_idx] <= base_cnt[sel_idx];
  end

  task automatic ev_check(input logic [7:0] kind, input logic [3:0] dat);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event unexpected kind %s got %b want none", kind, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.dat != dat) begin
        errors++;
        $display("FAIL event got %s %b want %s %b", kind, dat, e.kind, e.dat);
      end
    end
  endtask

  // Monitor: sole owner of the check counters.
  always @(negedge clock) begin
    while (pn_q.size() > 0) begin
      logic [31:0] a;
      logic [31:0] e;
      string       n;
      a = pa_q.pop_front();
      e = pe_q.pop_front();
      n = pn_q.pop_front();
      checks++;
      if (a != e) begin
        errors++;
        $display("FAIL %s got %0h want %0h", n, a, e);
      end
    end
    if (next_word)                   ev_check("N", transfer_register_select);
    if (next_word && dma_acknowledge != transfer_register_select)
      ev_check("D", dma_acknowledge);
    if (end_of_process)              ev_check("E", transfer_register_select);
    if (initialize_current_register) ev_check("I", transfer_register_select);
    if (set_request_mask != 4'b0000) ev_check("M", set_request_mask);
  end

  task automatic expect_ev(input logic [7:0] kind, input logic [3:0] dat);
    exp_q.push_back('{kind: kind, dat: dat});
  endtask

  task automatic probe(input string n, input logic [31:0] a, input logic [31:0] e);
    pn_q.push_back(n);
    pa_q.push_back(a);
    pe_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic program_count(input int ch, input logic [15:0] v);
    @(negedge clock);
    base_cnt[ch] = v;
    prog_ch      = ch[1:0];
    prog_stb     = 1'b1;
    @(negedge clock);
    prog_stb     = 1'b0;
  endtask

  task automatic wait_nw(input string n, input logic [3:0] ch);
    int t;
    logic hit;
    t = 0;
    hit = 1'b0;
    while (!hit && t < 200) begin
      @(negedge clock);
      t++;
      hit = next_word && (transfer_register_select == ch);
    end
    probe(n, {31'b0, hit}, 32'd1);
  endtask

  task automatic wait_eop(input string n);
    int t;
    logic hit;
    t = 0;
    hit = 1'b0;
    while (!hit && t < 300) begin
      @(negedge clock);
      t++;
      hit = end_of_process;
    end
    probe(n, {31'b0, hit}, 32'd1);
  endtask

  task automatic wait_dack(input string n);
    int t;
    logic hit;
    t = 0;
    hit = 1'b0;
    while (!hit && t < 100) begin
      @(negedge clock);
      t++;
      hit = (dma_acknowledge != 4'b0000);
    end
    probe(n, {31'b0, hit}, 32'd1);
  endtask

  task automatic drain(input string n);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    cycles(2);
    probe(n, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    reset_n = 1'b0;
    dma_request = '0;
    request_mask = '0;
    controller_disable = 1'b0;
    rotating_priority = 1'b0;
    transfer_mode = 8'h55;
    autoinitialize_config = '0;
    address_hold_config_ch = 4'b0100;
    decrement_address_config_ch = 4'b0010;
    hold_acknowledge = 1'b1;
    clear_status = 1'b0;
    prog_stb = 1'b0;
    prog_ch = 2'd0;
    for (int i = 0; i < 4; i++) base_cnt[i] = 16'd100;

    cycles(2);
    probe("reset_hrq",   {31'b0, hold_request}, 32'd0);
    probe("reset_dack",  {28'b0, dma_acknowledge}, 32'd0);
    probe("reset_sel",   {28'b0, transfer_register_select}, 32'd0);
    probe("reset_tc",    {28'b0, terminal_count_status}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) program_count(i, 16'd100);

    // Disabled controller and masked channel produce no bus request.
    controller_disable = 1'b1;
    dma_request = 4'b1111;
    cycles(8);
    probe("disable_hrq", {31'b0, hold_request}, 32'd0);
    controller_disable = 1'b0;
    dma_request = 4'b0001;
    request_mask = 4'b0001;
    cycles(8);
    probe("mask_hrq", {31'b0, hold_request}, 32'd0);
    dma_request = 4'b0000;
    request_mask = 4'b0000;
    cycles(2);

    // Fixed priority, single mode: ch0 then ch2.
    expect_ev("N", 4'b0001);
    expect_ev("N", 4'b0100);
    dma_request = 4'b0101;
    wait_nw("fixed_ch0", 4'b0001);
    probe("ch0_addr_hold", {31'b0, address_hold_config}, 32'd0);
    dma_request = 4'b0100;
    wait_nw("fixed_ch2", 4'b0100);
    probe("ch2_addr_hold", {31'b0, address_hold_config}, 32'd1);
    probe("ch2_decrement", {31'b0, decrement_address_config}, 32'd0);
    dma_request = 4'b0000;
    drain("fixed_drain");

    // Rotating priority with all requests held: 0,1,2,3,0.
    do_reset();
    rotating_priority = 1'b1;
    expect_ev("N", 4'b0001);
    expect_ev("N", 4'b0010);
    expect_ev("N", 4'b0100);
    expect_ev("N", 4'b1000);
    expect_ev("N", 4'b0001);
    dma_request = 4'b1111;
    wait_nw("rot_0", 4'b0001);
    wait_nw("rot_1", 4'b0010);
    probe("ch1_decrement", {31'b0, decrement_address_config}, 32'd1);
    wait_nw("rot_2", 4'b0100);
    wait_nw("rot_3", 4'b1000);
    wait_nw("rot_0b", 4'b0001);
    dma_request = 4'b0000;
    drain("rot_drain");
    rotating_priority = 1'b0;

    // ch1 block mode, count 2: three transfers then TC with mask set.
    program_count(1, 16'h0002);
    transfer_mode = 8'b0000_1000;
    expect_ev("N", 4'b0010);
    expect_ev("N", 4'b0010);
    expect_ev("N", 4'b0010);
    expect_ev("E", 4'b0010);
    expect_ev("M", 4'b0010);
    dma_request = 4'b0010;
    wait_eop("blk_eop");
    dma_request = 4'b0000;
    drain("blk_drain");
    probe("blk_tc_status", {28'b0, terminal_count_status}, 32'h2);
    clear_status = 1'b1;
    cycles(1);
    clear_status = 1'b0;
    cycles(1);
    probe("clear_tc_status", {28'b0, terminal_count_status}, 32'h0);

    // ch3 block mode, count 1, autoinitialize: reload instead of mask.
    program_count(3, 16'h0001);
    transfer_mode = 8'b1000_0000;
    autoinitialize_config = 4'b1000;
    expect_ev("N", 4'b1000);
    expect_ev("N", 4'b1000);
    expect_ev("E", 4'b1000);
    expect_ev("I", 4'b1000);
    dma_request = 4'b1000;
    wait_eop("auto_eop");
    dma_request = 4'b0000;
    drain("auto_drain");
    probe("auto_tc_status", {28'b0, terminal_count_status}, 32'h8);
    autoinitialize_config = 4'b0000;

    // ch0 demand mode, DREQ withdrawn during the second transfer.
    program_count(0, 16'd100);
    transfer_mode = 8'h00;
    expect_ev("N", 4'b0001);
    expect_ev("N", 4'b0001);
    dma_request = 4'b0001;
    wait_nw("dem_first", 4'b0001);
    cycles(1);
    dma_request = 4'b0000;
    drain("dem_drain");
    cycles(4);
    probe("dem_hrq_low", {31'b0, hold_request}, 32'd0);

    // HLDA lost in S2, then reset asserted in S3 of the next grant.
    program_count(2, 16'd100);
    transfer_mode = 8'h10;
    dma_request = 4'b0100;
    wait_dack("abort_s1");
    @(posedge clock);
    #1 hold_acknowledge = 1'b0;
    cycles(4);
    probe("abort_dack", {28'b0, dma_acknowledge}, 32'h0);
    probe("abort_regrant_hrq", {31'b0, hold_request}, 32'd1);
    hold_acknowledge = 1'b1;
    wait_dack("regrant_s1");
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    probe("rst_hrq",  {31'b0, hold_request}, 32'd0);
    probe("rst_dack", {28'b0, dma_acknowledge}, 32'h0);
    probe("rst_sel",  {28'b0, transfer_register_select}, 32'h0);
    probe("rst_strobes", {28'b0, next_word, end_of_process, initialize_current_register,
                          |set_request_mask}, 32'h0);
    probe("rst_tc", {28'b0, terminal_count_status}, 32'h0);
    dma_request = 4'b0000;
    cycles(3);
    reset_n = 1'b1;
    drain("abort_drain");
    probe("abort_count_untouched", {16'b0, cur_cnt[2]}, 32'd100);

    cycles(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
